// File: rtl/uart_tx.sv
// Byte FIFO feeding an 8N1 serialiser (LSB first). It is the consumer of muarttx
// writes, and its status drives muartstat.
module uart_tx #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CLKDIV = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     ovf_clr,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     txd
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [15:0]   BRELOAD = 16'(CLKDIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [15:0]     bcnt_q, bcnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            txd_q, txd_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            push;
    logic            pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign wr_ready   = (count_q != FULL);
    assign push       = wr_valid & wr_ready;
    assign ovf        = ovf_q;
    assign fifo_count = count_q;
    assign busy       = (count_q != '0) || (state_q != StIdle);
    assign txd        = txd_q;

    always_comb begin
        state_d = state_q;
        bcnt_d  = (bcnt_q != 16'd0) ? bcnt_q - 16'd1 : bcnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    bcnt_d  = BRELOAD;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bcnt_q == 16'd0) begin
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bidx_d  = 3'd0;
                    bcnt_d  = BRELOAD;
                    state_d = StData;
                end
            end
            StData: begin
                if (bcnt_q == 16'd0) begin
                    bcnt_d = BRELOAD;
                    if (bidx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bcnt_q == 16'd0) begin
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        bcnt_d  = BRELOAD;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set has priority over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_valid && !wr_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            bcnt_q   <= 16'd0;
            bidx_q   <= 3'd0;
            shreg_q  <= 8'd0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            bidx_q   <= bidx_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random bench for uart_tx: cycle-exact frame checks, overflow handling,
// async reset, and a line receiver comparing every frame against a byte scoreboard.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       ovf_clr = 1'b0;
    logic       wr_ready;
    logic       ovf;
    logic [2:0] fifo_count;
    logic       busy;
    logic       txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepted = 0;
    int started = 0;
    int started_base = 0;
    int rejected = 0;
    logic [7:0] sb_q[$];

    uart_tx #(.DEPTH(4), .CLKDIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
        .fifo_count (fifo_count),
        .busy       (busy),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bytes queued = accepted pushes minus frames whose start bit has appeared.
    function automatic int mcount();
        return accepted - (started - started_base);
    endfunction

    task automatic push(input logic [7:0] b);
        if (mcount() != 4) begin
            sb_q.push_back(b);
            accepted++;
        end else begin
            rejected++;
        end
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k < 4) return 1'b0;
        if (k < 36) return b[(k - 4) / 4];
        return 1'b1;
    endfunction

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic stale;
        logic [7:0] rb;
        int e0;

        // Receiver: samples mid-bit on the falling clock edge.
        fork
            begin
                int ph = -1;
                logic [7:0] sh = 8'd0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        ph = -1;
                    end else if (ph < 0) begin
                        if (txd === 1'b0) begin
                            ph = 0;
                            started++;
                        end
                    end else begin
                        ph++;
                        if (ph == 2) begin
                            check("rx_start", txd, 1'b0);
                        end else if (ph >= 6 && ph <= 34 && (ph - 6) % 4 == 0) begin
                            sh[(ph - 6) / 4] = txd;
                        end else if (ph == 38) begin
                            check("rx_stop", txd, 1'b1);
                            if (sb_q.size() == 0) begin
                                checks++;
                                errors++;
                                $error("FAIL rx_extra observed=%0h expected=none", sh);
                            end else begin
                                check("rx_byte", sh, sb_q.pop_front());
                            end
                        end else if (ph == 39) begin
                            ph = -1;
                        end
                    end
                end
            end
        join_none

        // Reset state
        step();
        step();
        check("rst_txd", txd, 1'b1);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        rst = 1'b0;
        step();

        // Single frame 0xA5, cycle exact
        push(8'hA5);
        check("a5_pre_txd", txd, 1'b1);
        check("a5_pre_cnt", fifo_count, 3'd1);
        check("a5_pre_busy", busy, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step();
            check($sformatf("a5_bit%0d", k), txd, fbit(8'hA5, k));
        end
        check("a5_busy40", busy, 1'b1);
        step();
        check("a5_busy41", busy, 1'b0);
        step();

        // Back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        for (int k = 0; k < 80; k++) begin
            if (k != 0) step();
            rb = (k < 40) ? 8'h00 : 8'hFF;
            check($sformatf("b2b_%0d", k), txd, fbit(rb, (k < 40) ? k : k - 40));
        end
        step();
        check("b2b_busy", busy, 1'b0);

        // Overflow while a frame is in flight
        push(8'h11);
        e0 = cyc;
        step();
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        check("full_cnt", fifo_count, 3'd4);
        check("full_ready", wr_ready, 1'b0);
        check("full_ovf0", ovf, 1'b0);
        push(8'h99);
        check("ovf_set", ovf, 1'b1);
        check("ovf_cnt", fifo_count, 3'd4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 1'b0);

        // Push on the cycle the STOP state pops from a full FIFO
        while (cyc < e0 + 40) step();
        check("pop_edge_ready", wr_ready, 1'b0);
        push(8'h77);
        check("pop_edge_ovf", ovf, 1'b1);
        check("pop_edge_ready1", wr_ready, 1'b1);
        check("pop_edge_cnt", fifo_count, 3'd3);
        push(8'h42);
        check("pop_edge_push", fifo_count, 3'd4);
        wait_idle(400);
        check("sb_empty1", sb_q.size(), 0);

        // Async reset mid-DATA with 3 bytes queued
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        repeat (8) step();
        check("mid_cnt", fifo_count, 3'd3);
        rst = 1'b1;
        #1;
        check("arst_txd", txd, 1'b1);
        check("arst_cnt", fifo_count, 3'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", wr_ready, 1'b1);
        sb_q.delete();
        step();
        step();
        accepted = 0;
        started_base = started;
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (txd !== 1'b1) stale = 1'b1;
        end
        check("no_stale", stale, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // Random push stream
        rejected = 0;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 14)) step();
            check("rnd_ready", wr_ready, (mcount() != 4) ? 1'b1 : 1'b0);
            push(8'($urandom));
        end
        wait_idle(400);
        check("sb_empty2", sb_q.size(), 0);
        check("rnd_ovf", ovf, (rejected != 0) ? 1'b1 : 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
